// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle for hazard_scoreboard_unit. Optional statistics signals
// appear only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_unit_if #(
    parameter int NB_REG_ADDRESS = 5
`ifdef HAZARD_STATS_EN
    , parameter int NB_STATS = 32
`endif
);
    logic [NB_REG_ADDRESS-1:0] i_rs_if_id;
    logic [NB_REG_ADDRESS-1:0] i_rt_if_id;
    logic                      i_rs_used;
    logic                      i_rt_used;
    logic [NB_REG_ADDRESS-1:0] i_rt_id_ex;
    logic                      i_mem_read_id_ex;
    logic                      i_jump_branch;
    logic                      i_branch;
    logic                      o_risk_detected;
    logic                      o_no_risk_detected;
    logic                      o_if_flush;
    logic                      o_flush_busy;
`ifdef HAZARD_STATS_EN
    logic                      i_stats_clear;
    logic [NB_STATS-1:0]       o_stall_count;
    logic [NB_STATS-1:0]       o_flush_count;
`endif

    modport master (
        output i_rs_if_id, i_rt_if_id, i_rs_used, i_rt_used,
               i_rt_id_ex, i_mem_read_id_ex, i_jump_branch, i_branch,
        input  o_risk_detected, o_no_risk_detected, o_if_flush, o_flush_busy
`ifdef HAZARD_STATS_EN
        , output i_stats_clear
        , input  o_stall_count, o_flush_count
`endif
    );

    modport slave (
        input  i_rs_if_id, i_rt_if_id, i_rs_used, i_rt_used,
               i_rt_id_ex, i_mem_read_id_ex, i_jump_branch, i_branch,
        output o_risk_detected, o_no_risk_detected, o_if_flush, o_flush_busy
`ifdef HAZARD_STATS_EN
        , input  i_stats_clear
        , output o_stall_count, o_flush_count
`endif
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard scoreboard plus multi-cycle wrong-path flush sequencer for the
// 5-stage MIPS ID stage. Define HAZARD_STATS_EN to add stall/flush counters.
module hazard_scoreboard_unit #(
    parameter int NB_REG_ADDRESS = 5,
    parameter int LOAD_LATENCY   = 1,
    parameter int FLUSH_CYCLES   = 1
`ifdef HAZARD_STATS_EN
    , parameter int NB_STATS     = 32
`endif
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    hazard_scoreboard_unit_if.slave bus
);

    localparam int         NB_ENTRIES = 2 ** NB_REG_ADDRESS;
    localparam logic [3:0] LOAD_INIT  = 4'(LOAD_LATENCY - 1);
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    logic [3:0] r_entry [NB_ENTRIES];
    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_next;
    logic       w_load;
    logic       w_immediate;
    logic       w_pending;
    logic       w_hazard;
    logic       w_take;
    logic       w_if_flush;

    assign w_load      = bus.i_mem_read_id_ex && (bus.i_rt_id_ex != '0);
    assign w_immediate = w_load &&
                         ((bus.i_rs_used && (bus.i_rt_id_ex == bus.i_rs_if_id)) ||
                          (bus.i_rt_used && (bus.i_rt_id_ex == bus.i_rt_if_id)));
    assign w_pending   = (bus.i_rs_used && (r_entry[bus.i_rs_if_id] != '0)) ||
                         (bus.i_rt_used && (r_entry[bus.i_rt_if_id] != '0));
    assign w_hazard    = (r_state == IDLE) && (w_immediate || w_pending);
    assign w_take      = (bus.i_jump_branch || bus.i_branch) && !w_hazard;

    // NOTE: the scoreboard array is reset explicitly; a stale count left over
    // from before reset would stall an unrelated instruction afterwards.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NB_ENTRIES; i++) r_entry[i] <= '0;
        end else begin
            for (int i = 0; i < NB_ENTRIES; i++) begin
                if (w_load && (bus.i_rt_id_ex == NB_REG_ADDRESS'(i)))
                    r_entry[i] <= LOAD_INIT;
                else if (r_entry[i] != '0)
                    r_entry[i] <= r_entry[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned and infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_if_flush   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_if_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_next = FLUSH;
                        w_cnt_next   = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                // Requests seen here come from wrong-path fetches and are dropped.
                w_if_flush = 1'b1;
                if (r_cnt <= 3'd1) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.o_risk_detected    = w_hazard;
    assign bus.o_no_risk_detected = !w_hazard;
    assign bus.o_if_flush         = w_if_flush;
    assign bus.o_flush_busy       = (r_state == FLUSH);

`ifdef HAZARD_STATS_EN
    logic [NB_STATS-1:0] r_stall_count;
    logic [NB_STATS-1:0] r_flush_count;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (bus.i_stats_clear) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_hazard && !(&r_stall_count))
                r_stall_count <= r_stall_count + 1'b1;
            if (w_if_flush && !(&r_flush_count))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign bus.o_stall_count = r_stall_count;
    assign bus.o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: two hazard units with different latency/flush settings share
// one stimulus stream and are compared against a timestamp-based reference model.
module tb_hazard_scoreboard_unit;

    localparam int NB   = 5;
    localparam int NREG = 2 ** NB;
    localparam int LL_A = 1;
    localparam int FC_A = 2;
    localparam int LL_B = 3;
    localparam int FC_B = 3;

    typedef struct {
        logic [NB-1:0] rs;
        logic [NB-1:0] rt;
        logic          rs_used;
        logic          rt_used;
        logic [NB-1:0] rt_ex;
        logic          mem_read;
        logic          jb;
        logic          br;
        logic          clr;
    } stim_t;

    typedef struct {
        logic        risk;
        logic        flush;
        logic        busy;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_unit_if #(.NB_REG_ADDRESS(NB)) bus_a ();
    hazard_scoreboard_unit_if #(.NB_REG_ADDRESS(NB)) bus_b ();

    hazard_scoreboard_unit #(.NB_REG_ADDRESS(NB), .LOAD_LATENCY(LL_A), .FLUSH_CYCLES(FC_A))
        dut_a (.i_clock(clk), .i_reset_n(rst_n), .bus(bus_a));
    hazard_scoreboard_unit #(.NB_REG_ADDRESS(NB), .LOAD_LATENCY(LL_B), .FLUSH_CYCLES(FC_B))
        dut_b (.i_clock(clk), .i_reset_n(rst_n), .bus(bus_b));

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          ready     [2][NREG];
    int          flush_end [2];
    logic [31:0] m_stall   [2];
    logic [31:0] m_flush   [2];
    exp_t        q_exp [$];
    stim_t       idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t mk(input int rs, input int rt, input bit rs_used, input bit rt_used,
                                 input int rt_ex, input bit mem, input bit jb, input bit br);
        stim_t s;
        s.rs = NB'(rs);  s.rt = NB'(rt);  s.rs_used = rs_used;  s.rt_used = rt_used;
        s.rt_ex = NB'(rt_ex);  s.mem_read = mem;  s.jb = jb;  s.br = br;  s.clr = 1'b0;
        return s;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? LL_A : LL_B;
    endfunction

    function automatic int fcy(input int d);
        return (d == 0) ? FC_A : FC_B;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < NREG; r++) ready[d][r] = 0;
            flush_end[d] = 0;
            m_stall[d]   = '0;
            m_flush[d]   = '0;
        end
    endtask

    // Predict this cycle's outputs for unit d, queue them, then advance past the edge.
    task automatic model_step(input int d, input stim_t s);
        exp_t e;
        bit   in_flush, imm, pend;
        in_flush = cyc < flush_end[d];
        imm  = s.mem_read && (s.rt_ex != 0) &&
               ((s.rs_used && s.rt_ex == s.rs) || (s.rt_used && s.rt_ex == s.rt));
        pend = (s.rs_used && s.rs != 0 && ready[d][s.rs] > cyc) ||
               (s.rt_used && s.rt != 0 && ready[d][s.rt] > cyc);
        e.risk      = !in_flush && (imm || pend);
        e.flush     = in_flush || ((s.jb || s.br) && !e.risk);
        e.busy      = in_flush;
        e.stall_cnt = m_stall[d];
        e.flush_cnt = m_flush[d];
        q_exp.push_back(e);
        if (s.mem_read && s.rt_ex != 0) ready[d][s.rt_ex] = cyc + lat(d);
        if (!in_flush && e.flush) flush_end[d] = cyc + fcy(d);
        if (s.clr) begin
            m_stall[d] = '0;
            m_flush[d] = '0;
        end else begin
            if (e.risk  && m_stall[d] != '1) m_stall[d] = m_stall[d] + 1;
            if (e.flush && m_flush[d] != '1) m_flush[d] = m_flush[d] + 1;
        end
    endtask

    task automatic drive(input stim_t s);
        bus_a.i_rs_if_id = s.rs;       bus_b.i_rs_if_id = s.rs;
        bus_a.i_rt_if_id = s.rt;       bus_b.i_rt_if_id = s.rt;
        bus_a.i_rs_used  = s.rs_used;  bus_b.i_rs_used  = s.rs_used;
        bus_a.i_rt_used  = s.rt_used;  bus_b.i_rt_used  = s.rt_used;
        bus_a.i_rt_id_ex = s.rt_ex;    bus_b.i_rt_id_ex = s.rt_ex;
        bus_a.i_mem_read_id_ex = s.mem_read;  bus_b.i_mem_read_id_ex = s.mem_read;
        bus_a.i_jump_branch    = s.jb;        bus_b.i_jump_branch    = s.jb;
        bus_a.i_branch         = s.br;        bus_b.i_branch         = s.br;
`ifdef HAZARD_STATS_EN
        bus_a.i_stats_clear = s.clr;   bus_b.i_stats_clear = s.clr;
`endif
    endtask

    task automatic compare(input int d);
        exp_t        e;
        logic        risk, nrisk, flush, busy;
        logic [31:0] sc, fc;
        string       p;
        p = (d == 0) ? "a" : "b";
        if (d == 0) begin
            risk = bus_a.o_risk_detected;  nrisk = bus_a.o_no_risk_detected;
            flush = bus_a.o_if_flush;      busy = bus_a.o_flush_busy;
        end else begin
            risk = bus_b.o_risk_detected;  nrisk = bus_b.o_no_risk_detected;
            flush = bus_b.o_if_flush;      busy = bus_b.o_flush_busy;
        end
        sc = '0;
        fc = '0;
`ifdef HAZARD_STATS_EN
        sc = (d == 0) ? bus_a.o_stall_count : bus_b.o_stall_count;
        fc = (d == 0) ? bus_a.o_flush_count : bus_b.o_flush_count;
`endif
        if (q_exp.size() == 0) begin
            check({p, ".queue_underflow"}, 32'd1, 32'd0);
            return;
        end
        e = q_exp.pop_front();
        check($sformatf("%s.risk@%0d", p, cyc), risk, e.risk);
        check($sformatf("%s.no_risk@%0d", p, cyc), nrisk, !e.risk);
        check($sformatf("%s.if_flush@%0d", p, cyc), flush, e.flush);
        check($sformatf("%s.busy@%0d", p, cyc), busy, e.busy);
`ifdef HAZARD_STATS_EN
        check($sformatf("%s.stall_count@%0d", p, cyc), sc, e.stall_cnt);
        check($sformatf("%s.flush_count@%0d", p, cyc), fc, e.flush_cnt);
`endif
    endtask

    // NOTE: inputs change 1 time unit after the rising edge with blocking
    // assignments and outputs are sampled on the falling edge, so nothing races.
    task automatic apply(input stim_t s);
        drive(s);
        model_step(0, s);
        model_step(1, s);
        @(negedge clk);
        compare(0);
        compare(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".a.risk"},    bus_a.o_risk_detected,    1'b0);
        check({tag, ".a.no_risk"}, bus_a.o_no_risk_detected, 1'b1);
        check({tag, ".a.if_flush"}, bus_a.o_if_flush,        1'b0);
        check({tag, ".a.busy"},    bus_a.o_flush_busy,       1'b0);
        check({tag, ".b.risk"},    bus_b.o_risk_detected,    1'b0);
        check({tag, ".b.no_risk"}, bus_b.o_no_risk_detected, 1'b1);
        check({tag, ".b.if_flush"}, bus_b.o_if_flush,        1'b0);
        check({tag, ".b.busy"},    bus_b.o_flush_busy,       1'b0);
`ifdef HAZARD_STATS_EN
        check({tag, ".a.stall_count"}, bus_a.o_stall_count, 32'd0);
        check({tag, ".b.flush_count"}, bus_b.o_flush_count, 32'd0);
`endif
    endtask

    initial begin
        stim_t s;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        drive(idle);
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (2) apply(idle);

        // Load r5 with a dependent rs, then the same load with rs unused.
        apply(mk(5, 1, 1, 0, 5, 1, 0, 0));
        repeat (3) apply(mk(5, 1, 1, 0, 0, 0, 0, 0));
        apply(mk(5, 1, 0, 0, 5, 1, 0, 0));
        repeat (3) apply(mk(5, 1, 0, 0, 0, 0, 0, 0));

        // Load r8 with a dependent rt held in ID.
        apply(mk(2, 8, 0, 1, 8, 1, 0, 0));
        repeat (4) apply(mk(2, 8, 0, 1, 0, 0, 0, 0));

        // Load to r0 never stalls.
        apply(mk(0, 0, 1, 1, 0, 1, 0, 0));
        repeat (2) apply(mk(0, 0, 1, 1, 0, 0, 0, 0));

        // Branch pulse, then a jump with a second jump during the flush.
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
        repeat (4) apply(idle);
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 1, 0));
        repeat (4) apply(idle);

        // Stall and branch together; branch held while the stall clears.
        apply(mk(5, 0, 1, 0, 5, 1, 0, 1));
        repeat (3) apply(mk(5, 0, 1, 0, 0, 0, 0, 1));
        repeat (4) apply(idle);

        // Back-to-back loads to one register, then independent registers.
        apply(mk(7, 3, 1, 1, 7, 1, 0, 0));
        apply(mk(7, 3, 1, 1, 7, 1, 0, 0));
        apply(mk(7, 3, 1, 1, 3, 1, 0, 0));
        apply(mk(4, 7, 1, 1, 4, 1, 0, 0));
        repeat (4) apply(mk(7, 4, 1, 1, 0, 0, 0, 0));

        // Explicit statistics clear followed by fresh activity.
        s = idle;
        s.clr = 1'b1;
        apply(s);
        apply(mk(6, 0, 1, 0, 6, 1, 0, 0));
        repeat (2) apply(mk(6, 0, 1, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 1));
        repeat (3) apply(idle);

        // Random traffic over a small register set.
        for (int i = 0; i < 300; i++) begin
            s.rs       = NB'($urandom_range(0, 7));
            s.rt       = NB'($urandom_range(0, 7));
            s.rs_used  = 1'($urandom_range(0, 1));
            s.rt_used  = 1'($urandom_range(0, 1));
            s.rt_ex    = NB'($urandom_range(0, 7));
            s.mem_read = ($urandom_range(0, 2) == 0);
            s.jb       = ($urandom_range(0, 9) == 0);
            s.br       = ($urandom_range(0, 9) == 0);
            s.clr      = ($urandom_range(0, 31) == 0);
            apply(s);
        end
        repeat (4) apply(idle);

        // Asynchronous reset mid-flush with r9 still pending in unit b.
        apply(mk(1, 2, 0, 0, 9, 1, 1, 0));
        drive(idle);
        #2;
        check("pre_reset.a.busy", bus_a.o_flush_busy, 1'(cyc < flush_end[0]));
        check("pre_reset.b.busy", bus_b.o_flush_busy, 1'(cyc < flush_end[1]));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
        repeat (3) apply(mk(9, 9, 1, 1, 0, 0, 0, 0));
        repeat (2) apply(idle);

        check("queue_empty", q_exp.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the load-use/flush hazard unit for the 5-stage MIPS pipeline.
- Adds a per-register load scoreboard for multi-cycle data memory, and a flush sequencer for a configurable number of wrong-path kill cycles.
- Sits beside the ID stage. Drives PC/IF_ID write-enable (stall), ID_EX bubble insertion and IF_ID flush.

Parameters:
- NB_REG_ADDRESS, 5, register address width; the scoreboard has 2**NB_REG_ADDRESS entries.
- LOAD_LATENCY, 1, cycles after a load leaves ID/EX before its result is forwardable. 1 gives classic single-bubble behaviour. Legal range 1..15.
- FLUSH_CYCLES, 1, consecutive cycles o_if_flush stays high per taken jump/branch. Legal range 1..7.
- NB_STATS, 32, width of the statistics counters (optional feature only).

Ports:
- i_clock  in  1  pipeline clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rs_if_id  in  NB_REG_ADDRESS  rs of the instruction in ID.
- i_rt_if_id  in  NB_REG_ADDRESS  rt of the instruction in ID.
- i_rs_used  in  1  the ID instruction reads rs.
- i_rt_used  in  1  the ID instruction reads rt.
- i_rt_id_ex  in  NB_REG_ADDRESS  destination rt of the instruction in ID/EX.
- i_mem_read_id_ex  in  1  the ID/EX instruction is a load.
- i_jump_branch  in  1  jump decoded in ID.
- i_branch  in  1  taken branch resolved in ID.
- o_risk_detected  out  1  stall: hold PC and IF_ID, bubble ID_EX.
- o_no_risk_detected  out  1  always ~o_risk_detected.
- o_if_flush  out  1  kill the IF_ID contents.
- o_flush_busy  out  1  flush sequencer is not IDLE.

Behaviour:
- Register 0 is never tracked. A hazard on address 0 never stalls.
- Scoreboard:
  - Each entry is a 4-bit down-counter, reset to 0.
  - Every rising edge, every nonzero entry decrements by 1 (saturates at 0).
  - If i_mem_read_id_ex=1 and i_rt_id_ex!=0, entry[i_rt_id_ex] loads LOAD_LATENCY-1. The load overrides the decrement for that entry.
- Stall (combinational):
  - immediate = i_mem_read_id_ex & i_rt_id_ex!=0 & ((i_rs_used & i_rt_id_ex==i_rs_if_id) | (i_rt_used & i_rt_id_ex==i_rt_if_id)).
  - pending = (i_rs_used & entry[rs]!=0) | (i_rt_used & entry[rt]!=0).
  - o_risk_detected = immediate | pending.
  - With LOAD_LATENCY=1 every entry stays 0, so o_risk_detected = immediate: a single bubble.
  - Latency: a dependent instruction stalls exactly LOAD_LATENCY cycles after the load reaches ID/EX.
- Flush sequencer FSM, states IDLE and FLUSH, with a 3-bit counter cnt:
  - IDLE:
    - If (i_jump_branch|i_branch) & ~o_risk_detected: o_if_flush=1 this cycle (combinational).
    - If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in IDLE.
  - FLUSH: o_if_flush=1. cnt decrements each cycle. Return to IDLE when cnt reaches 1.
  - While in FLUSH, new jump/branch requests are ignored because they are wrong-path.
  - Stall and branch in the same cycle: stall wins. The branch is not acted on; it re-evaluates next cycle while still held in ID.
  - In FLUSH, o_risk_detected is forced to 0. Wrong-path instructions never stall. The scoreboard keeps counting.
- o_flush_busy = (state==FLUSH).
- Reset (asynchronous, any time, including mid-flush or mid-scoreboard-count):
  - All entries go to 0, state goes to IDLE, cnt goes to 0.
  - With quiescent inputs: o_risk_detected=0, o_no_risk_detected=1, o_if_flush=0, o_flush_busy=0.
- Back-to-back loads to the same register: the later load reloads the entry. Loads to different registers are tracked independently.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- With the macro defined, the block adds:
  - i_stats_clear (in, 1, synchronous clear).
  - o_stall_count (out, NB_STATS): increments each cycle o_risk_detected=1.
  - o_flush_count (out, NB_STATS): increments each cycle o_if_flush=1.
  - Both counters saturate at all-ones, reset to 0, and clear on i_stats_clear. Clear wins over increment.
- Without the macro, none of these ports or registers exist, and all other behaviour is identical.

Test Plan:
- LOAD_LATENCY=1: load with rt=5 in ID/EX; ID has rs=5, i_rs_used=1 -> o_risk_detected=1 for exactly 1 cycle, then 0. Same case with i_rs_used=0 -> no stall.
- LOAD_LATENCY=3: load rt=8; dependent rt=8 (i_rt_used=1) held in ID -> stall high for 3 consecutive cycles. A load to rt=0 -> no stall ever.
- FLUSH_CYCLES=2: i_branch pulse for 1 cycle -> o_if_flush high 2 cycles, o_flush_busy high on cycle 2. A second i_jump_branch during FLUSH -> still exactly 2 flush cycles.
- Stall and i_branch in the same cycle -> o_if_flush=0 that cycle. With i_branch still high on the next cycle, once the stall clears -> o_if_flush=1.
- Assert i_reset_n=0 asynchronously in mid-FLUSH with scoreboard entry[9]=2 -> outputs go to reset values immediately. After release, a dependent instruction on r9 -> no stall.
- HAZARD_STATS_EN: 3 stall cycles plus 2 flush cycles -> o_stall_count=3, o_flush_count=2. i_stats_clear -> both 0 next edge.
